sr_ff_driver: RTL and testbench
===============================

Name: sr_ff_driver

Overview:
- Stimulus engine on the driving side of an SR master-slave flip-flop interface.
- Accepts target bits over a valid/ready handshake and converts each to legal S/R excitation, holding it for a programmable number of clocks.
- Reads back Q/Q_L after a settle window and reports completion, mismatch and illegal complementary outputs.
- Keeps saturating transaction and error counters. Sits between a test sequencer (or control FSM) and an SR flip-flop instance.

Parameters:
- DRIVE_CYC, 2, clocks S/R are held asserted per transaction (1..15).
- SETTLE_CYC, 1, clocks with S=R=0 between release and readback (0..15).
- MIN_EXC, 1, 1 = apply hold (S=R=0) when Q_FB already equals target; 0 = always drive set/reset.
- CNT_W, 8, width of TXN_CNT and ERR_CNT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- TGT_VALID  in  1  target bit offered.
- TGT_BIT  in  1  desired flip-flop state.
- TGT_READY  out  1  driver can accept a target.
- S  out  1  set excitation to flip-flop.
- R  out  1  reset excitation to flip-flop.
- Q_FB  in  1  flip-flop Q readback.
- QL_FB  in  1  flip-flop Q_L readback.
- DONE  out  1  one-cycle pulse: transaction checked.
- MISMATCH  out  1  one-cycle pulse with DONE: Q_FB != target.
- ILLEGAL  out  1  one-cycle pulse with DONE: Q_FB == QL_FB.
- STICKY_ERR  out  1  set by any MISMATCH/ILLEGAL, cleared only by RST.
- TXN_CNT  out  CNT_W  completed transactions, saturating.
- ERR_CNT  out  CNT_W  transactions with MISMATCH or ILLEGAL, saturating.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; S=R=0; TGT_READY=1.
  - DONE=MISMATCH=ILLEGAL=STICKY_ERR=0; TXN_CNT=ERR_CNT=0.
  - RST mid-transaction aborts immediately; S/R drop to 0 asynchronously; no DONE is issued.
- All outputs are registered. TGT_READY=1 only in IDLE.
- States: IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE.
- IDLE:
  - On TGT_VALID&TGT_READY at an edge, latch TGT_BIT into tgt and Q_FB into q0, then go to DRIVE. Load a down-counter with DRIVE_CYC-1.
  - TGT_VALID without TGT_READY is ignored; the source must hold it.
- DRIVE:
  - S=tgt&~hold, R=~tgt&~hold, where hold = MIN_EXC & (q0==tgt).
  - S=R=1 is never produced under any input.
  - Stays exactly DRIVE_CYC cycles, then goes to SETTLE (or to CHECK if SETTLE_CYC=0).
- SETTLE: S=R=0 for exactly SETTLE_CYC cycles, then CHECK.
- CHECK (one cycle):
  - Sample Q_FB and QL_FB.
  - MISMATCH = (Q_FB != tgt); ILLEGAL = (Q_FB == QL_FB).
  - DONE, MISMATCH and ILLEGAL are registered and are high during the first cycle back in IDLE, concurrent with TGT_READY=1.
- Latency: accept edge to DONE high = 1 + DRIVE_CYC + SETTLE_CYC + 1 clocks. Default is 5 clocks.
- Back-to-back: a new target may be accepted at the same edge where DONE is high (IDLE), giving a transaction every DRIVE_CYC+SETTLE_CYC+2 clocks.
- Counters:
  - TXN_CNT increments by 1 on each DONE.
  - ERR_CNT increments on DONE&(MISMATCH|ILLEGAL); a transaction with both flags counts once.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - STICKY_ERR sets in the same cycle ERR_CNT updates.
- Q_FB/QL_FB are treated as synchronous to CLK; no synchronizer.

Test Plan:
- Reset then set: RST pulse; TGT_BIT=1 with Q_FB=0 -> S=1,R=0 for 2 clocks, then S=R=0 for 1 clock; DONE at accept+5; MISMATCH=0; TXN_CNT=1.
- Clear path: target 0 with Q_FB=1, flop model correct -> R=1 for 2 clocks; DONE=1, MISMATCH=0, ERR_CNT=0.
- Hold excitation: MIN_EXC=1, target 1 with Q_FB already 1 -> S=R=0 throughout; DONE still at +5; with MIN_EXC=0 -> S=1 for 2 clocks.
- Fault detect: flop model forces Q_FB=QL_FB=0, target 1 -> DONE=1, MISMATCH=1, ILLEGAL=1; ERR_CNT=1 (not 2); STICKY_ERR=1 and stays after later clean transactions.
- Back-to-back and saturation: CNT_W=2, hold TGT_VALID=1 for 5 transactions -> accepts spaced 5 clocks apart; TXN_CNT sequence 1,2,3,3,3.
- Mid-op reset: assert RST while in DRIVE with S=1 -> S drops in the same cycle; after release TGT_READY=1, no DONE pulse, counters=0.

Source files
------------

// File: rtl/sr_ff_driver.sv
// Drives legal S/R excitation into an SR master-slave flip-flop for each accepted target bit,
// then reads Q/Q_L back and reports completion, mismatch, illegal outputs and saturating counts.
`timescale 1ns/1ps
module sr_ff_driver #(
  parameter int DRIVE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  parameter int MIN_EXC    = 1,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TGT_VALID,
  input  logic             TGT_BIT,
  output logic             TGT_READY,
  output logic             S,
  output logic             R,
  input  logic             Q_FB,
  input  logic             QL_FB,
  output logic             DONE,
  output logic             MISMATCH,
  output logic             ILLEGAL,
  output logic             STICKY_ERR,
  output logic [CNT_W-1:0] TXN_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  localparam logic [3:0]       DRIVE_LOAD  = 4'(DRIVE_CYC - 1);
  localparam logic [3:0]       SETTLE_LOAD = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam bit               HAS_SETTLE  = (SETTLE_CYC > 0);
  localparam bit               HOLD_EN     = (MIN_EXC != 0);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             q0_q, q0_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             mism_q, mism_d;
  logic             ill_q, ill_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             hold_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    q0_d     = q0_q;
    done_d   = 1'b0;
    mism_d   = 1'b0;
    ill_d    = 1'b0;
    sticky_d = sticky_q;
    txn_d    = txn_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (TGT_VALID && ready_q) begin
          tgt_d   = TGT_BIT;
          q0_d    = Q_FB;
          cnt_d   = DRIVE_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          if (HAS_SETTLE) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        mism_d  = (Q_FB != tgt_q);
        ill_d   = (Q_FB == QL_FB);
        if (txn_q != CNT_MAX) begin
          txn_d = txn_q + 1'b1;
        end
        // A transaction with both faults still counts as a single error.
        if (mism_d || ill_d) begin
          sticky_d = 1'b1;
          if (err_q != CNT_MAX) begin
            err_d = err_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Excitation is decoded from the next state so S/R leave a flop and are never both high.
    hold_d  = HOLD_EN && (q0_d == tgt_d);
    s_d     = (state_d == ST_DRIVE) && tgt_d && !hold_d;
    r_d     = (state_d == ST_DRIVE) && !tgt_d && !hold_d;
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      tgt_q    <= 1'b0;
      q0_q     <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      mism_q   <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
      txn_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      q0_q     <= q0_d;
      s_q      <= s_d;
      r_q      <= r_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      mism_q   <= mism_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
      txn_q    <= txn_d;
      err_q    <= err_d;
    end
  end

  assign TGT_READY  = ready_q;
  assign S          = s_q;
  assign R          = r_q;
  assign DONE       = done_q;
  assign MISMATCH   = mism_q;
  assign ILLEGAL    = ill_q;
  assign STICKY_ERR = sticky_q;
  assign TXN_CNT    = txn_q;
  assign ERR_CNT    = err_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Two driver instances (default config, and MIN_EXC=0/CNT_W=2/no settle) share random targets;
// each drives its own SR flop model with injectable faults and is checked by a scoreboard.
`timescale 1ns/1ps
module tb_sr_ff_driver;

  localparam int N   = 2;
  localparam int NTX = 150;

  function automatic int dcyc(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int scyc(int i); return (i == 0) ? 1 : 0; endfunction
  function automatic bit mexc(int i); return (i == 0); endfunction
  function automatic int cmax(int i); return (i == 0) ? 255 : 3; endfunction

  typedef struct {
    int   acc;
    logic s;
    logic r;
    logic mism;
    logic ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tgt_valid = 1'b0;
  logic tgt_bit = 1'b0;
  logic [1:0] fault_next = 2'd0;   // 0 ok, 1 Q=QL=0, 2 Q=QL=1, 3 flop stuck

  logic [N-1:0] s, r, rdy, done, mism, ill, sticky, qfb, qlfb;
  logic [7:0]   txn [N];
  logic [7:0]   err [N];
  logic [N-1:0] fq = '0;
  logic [1:0]   fault_cur [N] = '{2'd0, 2'd0};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int CW = (gi == 0) ? 8 : 2;
    logic [CW-1:0] txn_l, err_l;
    sr_ff_driver #(
      .DRIVE_CYC ((gi == 0) ? 2 : 3),
      .SETTLE_CYC((gi == 0) ? 1 : 0),
      .MIN_EXC   ((gi == 0) ? 1 : 0),
      .CNT_W     (CW)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .TGT_VALID (tgt_valid),
      .TGT_BIT   (tgt_bit),
      .TGT_READY (rdy[gi]),
      .S         (s[gi]),
      .R         (r[gi]),
      .Q_FB      (qfb[gi]),
      .QL_FB     (qlfb[gi]),
      .DONE      (done[gi]),
      .MISMATCH  (mism[gi]),
      .ILLEGAL   (ill[gi]),
      .STICKY_ERR(sticky[gi]),
      .TXN_CNT   (txn_l),
      .ERR_CNT   (err_l)
    );
    assign txn[gi] = 8'(txn_l);
    assign err[gi] = 8'(err_l);
  end

  // SR flop models; a fault mode takes effect from the edge that accepts its transaction.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (tgt_valid && rdy[i]) fault_cur[i] <= fault_next;
      if (fault_cur[i] != 2'd3) begin
        if (s[i]) fq[i] <= 1'b1;
        else if (r[i]) fq[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    qfb  = '0;
    qlfb = '0;
    for (int i = 0; i < N; i++) begin
      case (fault_cur[i])
        2'd1: begin qfb[i] = 1'b0; qlfb[i] = 1'b0; end
        2'd2: begin qfb[i] = 1'b1; qlfb[i] = 1'b1; end
        default: begin qfb[i] = fq[i]; qlfb[i] = ~fq[i]; end
      endcase
    end
  end

  // Scoreboard state
  exp_t sbq [N][$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_txn [N] = '{0, 0};
  int   m_err [N] = '{0, 0};
  logic m_sticky [N] = '{1'b0, 1'b0};
  logic rst_prev = 1'b0;
  exp_t h, e;
  int   k, kd;
  logic q0, qa, drv, qu, qf, qlf;

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, i, act, expv, $time);
    end
  endtask

  // Monitor + predictor: samples on the falling edge, and right after an asynchronous reset.
  always @(negedge clk or posedge rst) begin
    if (rst && !rst_prev) begin
      rst_prev = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
        chk("rst_async_s", i, 32'(s[i]), 0);
        chk("rst_async_r", i, 32'(r[i]), 0);
      end
    end else if (rst) begin
      for (int i = 0; i < N; i++) begin
        chk("rst_s", i, 32'(s[i]), 0);
        chk("rst_r", i, 32'(r[i]), 0);
        chk("rst_ready", i, 32'(rdy[i]), 1);
        chk("rst_done", i, 32'(done[i]) | 32'(mism[i]) | 32'(ill[i]), 0);
        chk("rst_sticky", i, 32'(sticky[i]), 0);
        chk("rst_txn", i, 32'(txn[i]), 0);
        chk("rst_err", i, 32'(err[i]), 0);
        sbq[i].delete();
        m_txn[i] = 0;
        m_err[i] = 0;
        m_sticky[i] = 1'b0;
      end
    end else begin
      rst_prev = 1'b0;
      cyc++;
      for (int i = 0; i < N; i++) begin
        chk("sr_both_high", i, 32'(s[i] & r[i]), 0);
        if (sbq[i].size() > 0) begin
          h  = sbq[i][0];
          k  = cyc - h.acc;
          // DONE appears on the (1+DRIVE+SETTLE+1)th edge counting the accept edge as the first.
          kd = 1 + dcyc(i) + scyc(i) + 1;
          chk("s_exc", i, 32'(s[i]), (k <= dcyc(i)) ? 32'(h.s) : 0);
          chk("r_exc", i, 32'(r[i]), (k <= dcyc(i)) ? 32'(h.r) : 0);
          chk("ready_busy", i, 32'(rdy[i]), (k >= kd) ? 1 : 0);
          if (k >= kd) begin
            chk("done", i, 32'(done[i]), 1);
            chk("mismatch", i, 32'(mism[i]), 32'(h.mism));
            chk("illegal", i, 32'(ill[i]), 32'(h.ill));
            if (m_txn[i] < cmax(i)) m_txn[i]++;
            if (h.mism || h.ill) begin
              m_sticky[i] = 1'b1;
              if (m_err[i] < cmax(i)) m_err[i]++;
            end
            void'(sbq[i].pop_front());
          end else begin
            chk("done_early", i, 32'(done[i]), 0);
          end
        end else begin
          chk("idle_ready", i, 32'(rdy[i]), 1);
          chk("idle_done", i, 32'(done[i]), 0);
          chk("idle_sr", i, 32'(s[i] | r[i]), 0);
        end
        chk("txn_cnt", i, 32'(txn[i]), 32'(m_txn[i]));
        chk("err_cnt", i, 32'(err[i]), 32'(m_err[i]));
        chk("sticky", i, 32'(sticky[i]), 32'(m_sticky[i]));

        // Predict the outcome of a target accepted at the coming edge.
        if (tgt_valid && rdy[i]) begin
          q0  = qfb[i];
          qa  = fq[i];
          drv = !(mexc(i) && (q0 == tgt_bit));
          e.s = drv && tgt_bit;
          e.r = drv && !tgt_bit;
          qu  = (drv && fault_next != 2'd3) ? tgt_bit : qa;
          case (fault_next)
            2'd1: begin qf = 1'b0; qlf = 1'b0; end
            2'd2: begin qf = 1'b1; qlf = 1'b1; end
            default: begin qf = qu; qlf = ~qu; end
          endcase
          e.mism = (qf != tgt_bit);
          e.ill  = (qf == qlf);
          e.acc  = cyc;
          sbq[i].push_back(e);
        end
      end
    end
  end

  task automatic wait_accept();
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy[0] && w < 20) begin
      w++;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic random_txns(int n);
    for (int t = 0; t < n; t++) begin
      tgt_bit    = 1'($urandom_range(0, 1));
      fault_next = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      tgt_valid  = 1'b1;
      wait_accept();
      if ($urandom_range(0, 3) == 0) begin
        tgt_valid = 1'b0;
        repeat ($urandom_range(1, 7)) @(posedge clk);
        #2;
      end
    end
  endtask

  // Stimulus
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    random_txns(NTX);

    // Abort a transaction while the second instance is driving S.
    tgt_bit    = 1'b1;
    fault_next = 2'd0;
    tgt_valid  = 1'b1;
    wait_accept();
    tgt_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    random_txns(12);
    tgt_valid = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
